// File: rtl/icache_refill_engine_pkg.sv
// Shared constants and types for the instruction-cache line refill engine.
package icache_refill_engine_pkg;

   localparam int unsigned HW_W             = 16;
   localparam int unsigned WORD_W           = 32;
   localparam int unsigned BURST_HW_DEF     = 4;
   localparam int unsigned ADDR_WIDTH_DEF   = 32;
   localparam int unsigned TIMEOUT_DEF      = 255;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CMD     = 2'd1,
      ST_COLLECT = 2'd2
   } state_e;

   // Word-slot index width within a line; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned burst_hw);
      return (burst_hw / 2 > 1) ? $clog2(burst_hw / 2) : 1;
   endfunction

endpackage

// File: rtl/icache_refill_engine_word_packer.sv
// Packs 16-bit SDRAM beats into 32-bit big-endian instruction words.
module icache_refill_engine_word_packer
   import icache_refill_engine_pkg::*;
#(
   parameter int unsigned BURST_HW = BURST_HW_DEF,
   parameter int unsigned IDX_W    = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              beat_valid_i,
   input  logic [HW_W-1:0]   beat_data_i,
   output logic              word_valid_o,
   output logic [WORD_W-1:0] word_data_o,
   output logic [IDX_W-1:0]  word_index_o,
   output logic              last_beat_c_o
);

   localparam int unsigned CNT_W = $clog2(BURST_HW);

   logic [CNT_W-1:0]  cnt_q;
   logic [HW_W-1:0]   hi_q;
   logic              word_valid_q;
   logic [WORD_W-1:0] word_data_q;
   logic [IDX_W-1:0]  word_index_q;

   // Flags the beat that completes the line so the FSM can finish in step.
   always_comb begin
      last_beat_c_o = beat_valid_i && (cnt_q == CNT_W'(BURST_HW - 1));
   end

   // Beat counter, high-half holding register and word strobe generation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= '0;
         hi_q         <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
         word_index_q <= '0;
      end else begin
         word_valid_q <= 1'b0;
         if (clear_i) begin
            cnt_q <= '0;
         end else if (beat_valid_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!cnt_q[0]) begin
               hi_q <= beat_data_i;
            end else begin
               word_data_q  <= {hi_q, beat_data_i};
               word_index_q <= IDX_W'(cnt_q >> 1);
               word_valid_q <= 1'b1;
            end
         end
      end
   end

   assign word_valid_o = word_valid_q;
   assign word_data_o  = word_data_q;
   assign word_index_o = word_index_q;

endmodule

// File: rtl/icache_refill_engine.sv
// Line refill engine: one aligned SDRAM burst per miss, words to cache RAM.
module icache_refill_engine
   import icache_refill_engine_pkg::*;
#(
   parameter int unsigned BURST_HW       = BURST_HW_DEF,
   parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
   localparam int unsigned IDX_W         = idx_width(BURST_HW)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   output logic                  req_ready_o,
   output logic                  word_valid_o,
   output logic [WORD_W-1:0]     word_data_o,
   output logic [IDX_W-1:0]      word_index_o,
   output logic                  line_done_o,
   output logic                  fill_error_o,
   output logic                  sdr_cmd_valid_o,
   output logic [ADDR_WIDTH-1:0] sdr_cmd_addr_o,
   input  logic                  sdr_cmd_ready_i,
   input  logic                  sdr_rd_valid_i,
   input  logic [HW_W-1:0]       sdr_rd_data_i
);

   localparam int unsigned          TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BURST_HW - 1);

   state_e                state_q;
   logic                  req_ready_q;
   logic                  sdr_cmd_valid_q;
   logic [ADDR_WIDTH-1:0] sdr_cmd_addr_q;
   logic                  line_done_q;
   logic                  fill_error_q;
   logic [TMO_W-1:0]      tmo_q;
   logic [TMO_W-1:0]      tmo_d;
   logic                  tmo_fire_c;
   logic                  cmd_hs_c;
   logic                  beat_c;
   logic                  last_beat_c;

   // Handshake and beat qualifiers; beats outside COLLECT are stray.
   always_comb begin
      cmd_hs_c = (state_q == ST_CMD) && sdr_cmd_valid_q && sdr_cmd_ready_i;
      beat_c   = (state_q == ST_COLLECT) && sdr_rd_valid_i;
   end

   // Watchdog: counts consecutive cycles of no progress while busy.
   always_comb begin
      tmo_d      = '0;
      tmo_fire_c = 1'b0;
      if ((state_q == ST_CMD || state_q == ST_COLLECT) && !cmd_hs_c && !beat_c) begin
         if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_fire_c = 1'b1;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   // Refill FSM with registered handshake and status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= ST_IDLE;
         req_ready_q     <= 1'b1;
         sdr_cmd_valid_q <= 1'b0;
         sdr_cmd_addr_q  <= '0;
         line_done_q     <= 1'b0;
         fill_error_q    <= 1'b0;
      end else begin
         line_done_q  <= 1'b0;
         fill_error_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid_i && req_ready_q) begin
                  sdr_cmd_addr_q  <= req_addr_i & ~ALIGN_MASK;
                  sdr_cmd_valid_q <= 1'b1;
                  req_ready_q     <= 1'b0;
                  state_q         <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (cmd_hs_c) begin
                  sdr_cmd_valid_q <= 1'b0;
                  state_q         <= ST_COLLECT;
               end else if (tmo_fire_c) begin
                  sdr_cmd_valid_q <= 1'b0;
                  fill_error_q    <= 1'b1;
                  state_q         <= ST_IDLE;
               end
            end
            ST_COLLECT: begin
               if (last_beat_c) begin
                  line_done_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else if (tmo_fire_c) begin
                  fill_error_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               sdr_cmd_valid_q <= 1'b0;
               state_q         <= ST_IDLE;
            end
         endcase
      end
   end

   icache_refill_engine_word_packer #(
      .BURST_HW (BURST_HW),
      .IDX_W    (IDX_W)
   ) u_refill_word_packer (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (cmd_hs_c),
      .beat_valid_i  (beat_c),
      .beat_data_i   (sdr_rd_data_i),
      .word_valid_o  (word_valid_o),
      .word_data_o   (word_data_o),
      .word_index_o  (word_index_o),
      .last_beat_c_o (last_beat_c)
   );

   assign req_ready_o     = req_ready_q;
   assign sdr_cmd_valid_o = sdr_cmd_valid_q;
   assign sdr_cmd_addr_o  = sdr_cmd_addr_q;
   assign line_done_o     = line_done_q;
   assign fill_error_o    = fill_error_q;

endmodule

// File: tb/tb_icache_refill_engine.sv
// Scoreboard bench for the icache refill engine (BURST_HW=4, timeout 8).
module tb_icache_refill_engine;

   typedef struct packed {
      logic        wv;
      logic [31:0] data;
      logic [0:0]  idx;
      logic        ld;
      logic        fe;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        word_valid;
   logic [31:0] word_data;
   logic [0:0]  word_index;
   logic        line_done;
   logic        fill_error;
   logic        cmd_valid;
   logic [31:0] cmd_addr;
   logic        cmd_ready;
   logic        rd_valid;
   logic [15:0] rd_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   ev_t         exp_q[$];
   logic [31:0] cmd_q[$];
   logic        cmd_prev = 1'b0;

   icache_refill_engine #(
      .BURST_HW       (4),
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_valid_i     (req_valid),
      .req_addr_i      (req_addr),
      .req_ready_o     (req_ready),
      .word_valid_o    (word_valid),
      .word_data_o     (word_data),
      .word_index_o    (word_index),
      .line_done_o     (line_done),
      .fill_error_o    (fill_error),
      .sdr_cmd_valid_o (cmd_valid),
      .sdr_cmd_addr_o  (cmd_addr),
      .sdr_cmd_ready_i (cmd_ready),
      .sdr_rd_valid_i  (rd_valid),
      .sdr_rd_data_i   (rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected word/done/error events and command addresses.
   always @(negedge clk) begin
      ev_t e;
      logic [31:0] a;
      if (rst_n === 1'b1 && (word_valid || line_done || fill_error)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {61'd0, word_valid, line_done, fill_error}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("event_flags", {61'd0, word_valid, line_done, fill_error},
                  {61'd0, e.wv, e.ld, e.fe});
            if (e.wv) begin
               check("word_data", 64'(word_data), 64'(e.data));
               check("word_index", 64'(word_index), 64'(e.idx));
            end
         end
      end
      if (rst_n === 1'b1 && cmd_valid && !cmd_prev) begin
         if (cmd_q.size() == 0) begin
            check("unexpected_cmd", 64'(cmd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            a = cmd_q.pop_front();
            check("cmd_addr", 64'(cmd_addr), 64'(a));
         end
      end
      cmd_prev = cmd_valid;
   end

   task automatic push_word(input logic [31:0] d, input logic [0:0] i, input logic ld);
      ev_t e;
      e = '{wv: 1'b1, data: d, idx: i, ld: ld, fe: 1'b0};
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      ev_t e;
      e = '{wv: 1'b0, data: 32'd0, idx: 1'b0, ld: 1'b0, fe: 1'b1};
      exp_q.push_back(e);
   endtask

   // Present a request until accepted; returns at the negedge after acceptance.
   task automatic request(input logic [31:0] a, input logic [31:0] aligned);
      int n;
      @(negedge clk);
      cmd_q.push_back(aligned);
      req_valid = 1'b1;
      req_addr  = a;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("req_accept_timeout", 64'(n), 64'd0);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Wait for the command, optionally inject stray beats, then accept it.
   task automatic cmd_accept(input int w, input logic stray);
      int n;
      n = 0;
      while (!cmd_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("cmd_valid_timeout", 64'(n), 64'd0);
      repeat (w) begin
         rd_valid = stray;
         rd_data  = 16'hDEAD;
         @(negedge clk);
      end
      rd_valid  = 1'b0;
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   // Drive n beats (MSB-first from the packed vector), gap idle cycles between.
   task automatic send_beats(input logic [63:0] beats, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         rd_valid = 1'b1;
         rd_data  = beats[63 - 16*i -: 16];
         @(negedge clk);
         if (gap > 0 && i < n - 1) begin
            rd_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      rd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'd0;
      cmd_ready = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = 16'd0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {58'd0, req_ready, word_valid, line_done, fill_error, cmd_valid, word_index},
            {58'd0, 6'b100000});
      check("reset_data", {word_data, cmd_addr}, 64'd0);
      rst_n = 1'b1;

      // Basic fill, back-to-back beats.
      push_word(32'hAAAA_BBBB, 1'b0, 1'b0);
      push_word(32'hCCCC_DDDD, 1'b1, 1'b1);
      request(32'h0000_1236, 32'h0000_1234);
      cmd_accept(2, 1'b0);
      send_beats(64'hAAAA_BBBB_CCCC_DDDD, 4, 0);
      check("basic_ready_in_done_cycle", 64'(req_ready), 64'd0);
      @(negedge clk);
      check("basic_ready_after_done", 64'(req_ready), 64'd1);
      check("basic_data_hold", {31'd0, word_valid, word_data}, {31'd0, 1'b0, 32'hCCCC_DDDD});

      // Gapped beats.
      push_word(32'hAAAA_BBBB, 1'b0, 1'b0);
      push_word(32'hCCCC_DDDD, 1'b1, 1'b1);
      request(32'h0000_1236, 32'h0000_1234);
      cmd_accept(0, 1'b0);
      send_beats(64'hAAAA_BBBB_CCCC_DDDD, 4, 3);
      @(negedge clk);

      // Timeout in COLLECT after two beats.
      push_word(32'h1111_2222, 1'b0, 1'b0);
      push_err();
      request(32'h0000_0041, 32'h0000_0040);
      cmd_accept(0, 1'b0);
      send_beats(64'h1111_2222_0000_0000, 2, 0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check($sformatf("collect_tmo_c%0d", i), {62'd0, fill_error, req_ready},
               {62'd0, (i == 8), 1'b0});
      end
      @(negedge clk);
      check("collect_tmo_ready_next", {62'd0, fill_error, req_ready}, {62'd0, 2'b01});

      // Command stall timeout.
      push_err();
      request(32'h0000_0083, 32'h0000_0080);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check($sformatf("cmd_tmo_c%0d", i), {62'd0, fill_error, cmd_valid},
               {62'd0, (i == 8), (i < 8)});
      end
      @(negedge clk);
      check("cmd_tmo_ready_next", 64'(req_ready), 64'd1);

      // Async reset mid-COLLECT, then a clean fill.
      push_word(32'h5555_6666, 1'b0, 1'b0);
      request(32'h0000_0100, 32'h0000_0100);
      cmd_accept(1, 1'b0);
      send_beats(64'h5555_6666_0000_0000, 2, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_ctrl", {58'd0, req_ready, word_valid, line_done, fill_error, cmd_valid, word_index},
            {58'd0, 6'b100000});
      check("midreset_data", {word_data, cmd_addr}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_word(32'h1357_2468, 1'b0, 1'b0);
      push_word(32'h9ABC_DEF0, 1'b1, 1'b1);
      request(32'h0000_010F, 32'h0000_010C);
      cmd_accept(1, 1'b0);
      send_beats(64'h1357_2468_9ABC_DEF0, 4, 0);
      @(negedge clk);

      // Stray beats in IDLE and CMD, request held while busy.
      rd_valid = 1'b1;
      rd_data  = 16'hDEAD;
      repeat (3) @(negedge clk);
      rd_valid = 1'b0;
      push_word(32'h0102_0304, 1'b0, 1'b0);
      push_word(32'h0506_0708, 1'b1, 1'b1);
      request(32'h0000_2003, 32'h0000_2000);
      cmd_accept(2, 1'b1);
      cmd_q.push_back(32'h0000_3008);
      req_valid = 1'b1;
      req_addr  = 32'h0000_3009;
      send_beats(64'h0102_0304_0506_0708, 4, 0);
      check("busy_done_cycle", {62'd0, cmd_valid, req_ready}, {62'd0, 2'b00});
      @(negedge clk);
      check("busy_ready_cycle", {62'd0, cmd_valid, req_ready}, {62'd0, 2'b01});
      @(negedge clk);
      check("busy_held_accepted", {30'd0, cmd_valid, req_ready, cmd_addr},
            {30'd0, 2'b10, 32'h0000_3008});
      req_valid = 1'b0;
      push_word(32'hFEED_BEEF, 1'b0, 1'b0);
      push_word(32'hCAFE_F00D, 1'b1, 1'b1);
      cmd_accept(0, 1'b0);
      send_beats(64'hFEED_BEEF_CAFE_F00D, 4, 0);
      repeat (3) @(negedge clk);

      check("events_drained", 64'(exp_q.size()), 64'd0);
      check("cmds_drained", 64'(cmd_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
